// File: rtl/whitening_pkg.sv
// whitening_pkg: shared state encoding and default sizes for the whitening datapath
//   state_t        : sequencer states, 4-bit, IDLE=0 DONE=11 ERR=12
//   ADDR_W_DEF     : default ROM address width
//   N_SAMPLES_DEF  : default samples per ROM pass
package whitening_pkg;
    localparam int ADDR_W_DEF    = 14;
    localparam int N_SAMPLES_DEF = 16384;
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        CEN_GO     = 4'd1,
        CEN_STREAM = 4'd2,
        CEN_WAIT   = 4'd3,
        COV_GO     = 4'd4,
        COV_STREAM = 4'd5,
        COV_WAIT   = 4'd6,
        QR_GO      = 4'd7,
        QR_WAIT    = 4'd8,
        MUL_STREAM = 4'd9,
        MUL_FLUSH  = 4'd10,
        DONE       = 4'd11,
        ERR        = 4'd12
    } state_t;
endpackage

// File: rtl/whitening_sequencer_if.sv
// whitening_sequencer_if: sequencer <-> stage blocks bundle
//   master (sequencer): drives rom_addr/rom_en/sample_valid, go_* pulses, en_multi/en_mem3; reads *_busy
//   slave  (stages)   : the reverse
interface whitening_sequencer_if #(parameter int ADDR_W = 14);
    logic [ADDR_W-1:0] rom_addr;
    logic rom_en, sample_valid, go_cen, go_cov, go_qr, en_multi, en_mem3;
    logic cen_busy, cov_busy, qr_busy;
    modport master(output rom_addr, rom_en, sample_valid, go_cen, go_cov, go_qr, en_multi, en_mem3,
                   input cen_busy, cov_busy, qr_busy);
    modport slave(input rom_addr, rom_en, sample_valid, go_cen, go_cov, go_qr, en_multi, en_mem3,
                  output cen_busy, cov_busy, qr_busy);
endinterface

// File: rtl/busy_watch.sv
// busy_watch: waits for busy to rise then fall, with a watchdog on the whole wait
//   clk, rst_n : clock, async active-low reset
//   clear      : held high outside a wait state; restarts tracker and watchdog
//   busy       : busy flag of the stage being waited on
//   finished   : busy was seen high and is now low
//   timeout    : watchdog reached TIMEOUT cycles in this wait
module busy_watch #(
    parameter int TIMEOUT = 65535,
    parameter int TO_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic busy,
    output logic finished,
    output logic timeout
);
    logic            seen;
    logic [TO_W-1:0] cnt;
    // the wait cycle with cnt == TIMEOUT-1 is the TIMEOUT-th one
    assign timeout  = cnt == TO_W'(TIMEOUT - 1);
    assign finished = seen & ~busy;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen <= 1'b0;
            cnt  <= '0;
        end else if (clear) begin
            seen <= 1'b0;
            cnt  <= '0;
        end else begin
            seen <= seen | busy;
            if (!timeout) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/whitening_sequencer.sv
// whitening_sequencer: clock-enable sequencer for ROM -> centering -> covariance -> QR -> multiply/store
//   CLK_whitening, RST_whitening_n : clock, async active-low reset
//   GO_whitening                   : start request, honoured in IDLE/DONE/ERR
//   New_one                        : abort to IDLE, beats GO_whitening
//   bus (master)                   : ROM address stream, stage go pulses/enables, stage busy inputs
//   Whitening_busy/done/err        : run status
//   state_dbg                      : current state encoding
module whitening_sequencer
    import whitening_pkg::*;
#(
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int TIMEOUT   = 65535,
    parameter int TO_W      = 16
) (
    input  logic                  CLK_whitening,
    input  logic                  RST_whitening_n,
    input  logic                  GO_whitening,
    input  logic                  New_one,
    whitening_sequencer_if.master bus,
    output logic                  Whitening_busy,
    output logic                  Whitening_done,
    output logic                  Whitening_err,
    output logic [3:0]            state_dbg
);
    state_t state, nxt;
    logic   in_wait, wbusy, finished, timeout, last;
    assign last    = bus.rom_addr == ADDR_W'(N_SAMPLES - 1);
    assign in_wait = state inside {CEN_WAIT, COV_WAIT, QR_WAIT};
    assign wbusy   = state == CEN_WAIT ? bus.cen_busy : state == COV_WAIT ? bus.cov_busy : bus.qr_busy;
    busy_watch #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_watch (
        .clk(CLK_whitening), .rst_n(RST_whitening_n), .clear(!in_wait),
        .busy(wbusy), .finished(finished), .timeout(timeout)
    );
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERR: if (GO_whitening) nxt = CEN_GO;
            CEN_GO:          nxt = CEN_STREAM;
            CEN_STREAM:      if (last) nxt = CEN_WAIT;
            CEN_WAIT:        nxt = finished ? COV_GO : timeout ? ERR : state;
            COV_GO:          nxt = COV_STREAM;
            COV_STREAM:      if (last) nxt = COV_WAIT;
            COV_WAIT:        nxt = finished ? QR_GO : timeout ? ERR : state;
            QR_GO:           nxt = QR_WAIT;
            QR_WAIT:         nxt = finished ? MUL_STREAM : timeout ? ERR : state;
            MUL_STREAM:      if (last) nxt = MUL_FLUSH;
            // sample_valid is high only in the first flush cycle, so its fall marks the second
            MUL_FLUSH:       if (!bus.sample_valid) nxt = DONE;
            default:         nxt = IDLE;
        endcase
        if (New_one) nxt = IDLE;
    end
    assign bus.go_cen   = state == CEN_GO;
    assign bus.go_cov   = state == COV_GO;
    assign bus.go_qr    = state == QR_GO;
    assign bus.rom_en   = state inside {CEN_STREAM, COV_STREAM, MUL_STREAM};
    assign bus.en_multi = bus.sample_valid & (state inside {MUL_STREAM, MUL_FLUSH});
    assign Whitening_busy = !(state inside {IDLE, DONE, ERR});
    assign Whitening_done = state == DONE;
    assign Whitening_err  = state == ERR;
    assign state_dbg      = state;
    always_ff @(posedge CLK_whitening or negedge RST_whitening_n) begin
        if (!RST_whitening_n) begin
            state            <= IDLE;
            bus.rom_addr     <= '0;
            bus.sample_valid <= 1'b0;
            bus.en_mem3      <= 1'b0;
        end else begin
            state            <= nxt;
            // an abort kills the delayed enables too, so nothing is left high in IDLE
            bus.sample_valid <= bus.rom_en & ~New_one;
            bus.en_mem3      <= bus.en_multi & ~New_one;
            if (nxt inside {IDLE, CEN_GO, COV_GO, QR_GO}) bus.rom_addr <= '0;
            else if (bus.rom_en && !last) bus.rom_addr <= bus.rom_addr + 1'b1;
        end
    end
endmodule

// File: tb/tb_whitening_sequencer.sv
// tb_whitening_sequencer: directed bench; dut_a has TIMEOUT=100, dut_b TIMEOUT=20, both N_SAMPLES=8
module tb_whitening_sequencer;
    logic clk = 1'b0, rst_n = 1'b0, go = 1'b0, abort = 1'b0;
    logic cen_b = 1'b0, cov_b = 1'b0, qr_b = 1'b0;
    logic busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [3:0] st_a, st_b;
    int checks = 0, errors = 0;
    int t_done_a, t_done_b, t_err_a, t_err_b;
    int n_go_cen, n_go_cov, n_go_qr, n_qr_b, n_en, bursts, n_mem3, n_busy, sv_bad, m_bad;

    always #5 clk = ~clk;

    whitening_sequencer_if #(.ADDR_W(4)) ia ();
    whitening_sequencer_if #(.ADDR_W(4)) ib ();
    assign ia.cen_busy = cen_b;
    assign ia.cov_busy = cov_b;
    assign ia.qr_busy  = qr_b;
    assign ib.cen_busy = cen_b;
    assign ib.cov_busy = cov_b;
    assign ib.qr_busy  = qr_b;

    whitening_sequencer #(.N_SAMPLES(8), .ADDR_W(4), .TIMEOUT(100), .TO_W(16)) dut_a (
        .CLK_whitening(clk), .RST_whitening_n(rst_n), .GO_whitening(go), .New_one(abort),
        .bus(ia.master), .Whitening_busy(busy_a), .Whitening_done(done_a),
        .Whitening_err(err_a), .state_dbg(st_a)
    );
    whitening_sequencer #(.N_SAMPLES(8), .ADDR_W(4), .TIMEOUT(20), .TO_W(5)) dut_b (
        .CLK_whitening(clk), .RST_whitening_n(rst_n), .GO_whitening(go), .New_one(abort),
        .bus(ib.master), .Whitening_busy(busy_b), .Whitening_done(done_b),
        .Whitening_err(err_b), .state_dbg(st_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs_a();
        return {14'd0, ia.rom_addr, ia.rom_en, ia.sample_valid, ia.go_cen, ia.go_cov, ia.go_qr,
                ia.en_multi, ia.en_mem3, busy_a, done_a, err_a, st_a};
    endfunction

    // one 60-cycle run; cycle 0 is CEN_GO; stages raise busy 2 cycles after their go,
    // holding it through the stream and 5 cycles into the wait (QR: 5 cycles total)
    task automatic run(input int go_at, input bit stuck, input bit dead, input int rst_at);
        int cc = 1000, cv = 1000, cq = 1000, e = 0;
        logic pv = 1'b0, pm = 1'b0;
        t_done_a = -1; t_done_b = -1; t_err_a = -1; t_err_b = -1;
        n_go_cen = 0; n_go_cov = 0; n_go_qr = 0; n_qr_b = 0; n_en = 0;
        bursts = 0; n_mem3 = 0; n_busy = 0; sv_bad = 0; m_bad = 0;
        cen_b = 1'b0; cov_b = stuck; qr_b = 1'b0;
        abort = 1'b1; tick; abort = 1'b0;
        go = 1'b1; tick; go = 1'b0;
        for (int k = 0; k < 60; k++) begin
            cc = ia.go_cen ? 0 : cc + 1;
            cv = ia.go_cov ? 0 : cv + 1;
            cq = ia.go_qr  ? 0 : cq + 1;
            n_go_cen += int'(ia.go_cen);
            n_go_cov += int'(ia.go_cov);
            n_go_qr  += int'(ia.go_qr);
            n_qr_b   += int'(ib.go_qr);
            n_mem3   += int'(ia.en_mem3);
            n_busy   += int'(busy_a);
            if (ia.rom_en) begin
                chk("addr", 32'(ia.rom_addr), 32'(e));
                if (!pv) bursts++;
                e++;
                n_en++;
            end else e = 0;
            if (ia.sample_valid !== pv) sv_bad++;
            if (ia.en_mem3 !== pm) m_bad++;
            pv = ia.rom_en;
            pm = ia.en_multi;
            if (done_a && t_done_a < 0) t_done_a = k;
            if (done_b && t_done_b < 0) t_done_b = k;
            if (err_a && t_err_a < 0) t_err_a = k;
            if (err_b && t_err_b < 0) t_err_b = k;
            if (k == rst_at) begin
                chk("rst_pre_state", 32'(st_a), 32'd9);
                chk("rst_pre_addr", 32'(ia.rom_addr), 32'd5);
                rst_n = 1'b0;
                #1;
                chk("rst_async_outs", outs_a(), 32'd0);
                rst_n = 1'b1;
                pv = 1'b0;
                pm = 1'b0;
            end
            go = k == go_at;
            cen_b = cc >= 2 && cc < 14;
            cov_b = stuck || (cv >= 2 && cv < 14);
            qr_b  = !dead && cq >= 2 && cq < 7;
            tick;
        end
        go = 1'b0;
    endtask

    initial begin
        #3;
        chk("reset_outs", outs_a(), 32'd0);
        #14 rst_n = 1'b1;
        tick;
        chk("idle_state", 32'(st_a), 32'd0);

        run(-1, 1'b0, 1'b0, -1);
        chk("nom_done_cycle", 32'(t_done_a), 32'd48);
        chk("nom_done_cycle_b", 32'(t_done_b), 32'd48);
        chk("nom_go_cen", 32'(n_go_cen), 32'd1);
        chk("nom_go_cov", 32'(n_go_cov), 32'd1);
        chk("nom_go_qr", 32'(n_go_qr), 32'd1);
        chk("nom_bursts", 32'(bursts), 32'd3);
        chk("nom_rom_en", 32'(n_en), 32'd24);
        chk("nom_mem3", 32'(n_mem3), 32'd8);
        chk("nom_busy_cycles", 32'(n_busy), 32'd48);
        chk("nom_sv_delay", 32'(sv_bad), 32'd0);
        chk("nom_mem3_delay", 32'(m_bad), 32'd0);
        chk("nom_done_flag", 32'(done_a), 32'd1);
        chk("nom_busy_flag", 32'(busy_a), 32'd0);
        chk("nom_no_err", 32'(t_err_b), 32'hffffffff);

        go = 1'b1; abort = 1'b1;
        tick;
        go = 1'b0; abort = 1'b0;
        chk("go_abort_state", 32'(st_a), 32'd0);
        chk("go_abort_go_cen", 32'(ia.go_cen), 32'd0);
        chk("go_abort_done", 32'(done_a), 32'd0);
        tick;
        chk("go_abort_stays", 32'(st_a), 32'd0);

        run(18, 1'b0, 1'b0, -1);
        chk("goign_go_cen", 32'(n_go_cen), 32'd1);
        chk("goign_bursts", 32'(bursts), 32'd3);
        chk("goign_done_cycle", 32'(t_done_a), 32'd48);

        run(-1, 1'b1, 1'b0, -1);
        chk("stuck_err_cycle", 32'(t_err_b), 32'd44);
        chk("stuck_err_flag", 32'(err_b), 32'd1);
        chk("stuck_state_b", 32'(st_b), 32'd12);
        chk("stuck_no_go_qr", 32'(n_qr_b), 32'd0);
        chk("stuck_a_waiting", 32'(st_a), 32'd6);

        run(-1, 1'b0, 1'b1, -1);
        chk("dead_err_cycle", 32'(t_err_b), 32'd51);
        chk("dead_go_qr", 32'(n_go_qr), 32'd1);
        chk("dead_a_waiting", 32'(st_a), 32'd8);

        run(-1, 1'b0, 1'b0, 43);
        chk("rst_no_done", 32'(t_done_a), 32'hffffffff);
        chk("rst_idle", 32'(st_a), 32'd0);

        cen_b = 1'b0; cov_b = 1'b0; qr_b = 1'b0;
        go = 1'b1; tick; go = 1'b0;
        tick; tick; tick; tick;
        chk("abort_pre_state", 32'(st_a), 32'd2);
        chk("abort_pre_addr", 32'(ia.rom_addr), 32'd3);
        abort = 1'b1; tick; abort = 1'b0;
        chk("abort_state", 32'(st_a), 32'd0);
        chk("abort_rom_en", 32'(ia.rom_en), 32'd0);
        chk("abort_addr", 32'(ia.rom_addr), 32'd0);
        chk("abort_sv", 32'(ia.sample_valid), 32'd0);
        go = 1'b1; tick; go = 1'b0;
        chk("restart_go_cen", 32'(ia.go_cen), 32'd1);
        tick;
        chk("restart_addr0", {31'd0, ia.rom_en} << 4 | 32'(ia.rom_addr), 32'h10);
        tick;
        chk("restart_addr1", 32'(ia.rom_addr), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
